// File: rtl/crc16_pkg.sv
// Shared constants and types for the CRC-16 encoder and the CRC-16 decoder.
// Generator 0x8005 (x^16 implicit), non-reflected, preset 0x0000, no final XOR.
package crc16_pkg;

    localparam int DATA_W = 16;
    localparam int CRC_W  = 16;
    localparam int CW_W   = DATA_W + CRC_W;

    localparam logic [CRC_W-1:0] CRC16_POLY = 16'h8005;
    localparam logic [CRC_W-1:0] CRC16_INIT = 16'h0000;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } enc_state_t;

endpackage

// File: rtl/crc16_serial_encoder_if.sv
// Handshake/data bundle between a message source and crc16_serial_encoder.
// The source (master) drives sync/msg; the encoder (slave) returns busy, valid
// and the codeword. With CRC16_ENC_ERRINJ_EN defined, the source also drives
// inj_en/inj_pos to flip one codeword bit for exercising the decoder.
interface crc16_serial_encoder_if;
    import crc16_pkg::*;

    logic              sync;
    logic [DATA_W-1:0] msg;
    logic              busy;
    logic              valid;
    logic [CW_W-1:0]   codeword;
`ifdef CRC16_ENC_ERRINJ_EN
    logic              inj_en;
    logic [4:0]        inj_pos;
`endif

`ifdef CRC16_ENC_ERRINJ_EN
    modport master (output sync, output msg, output inj_en, output inj_pos,
                    input busy, input valid, input codeword);
    modport slave  (input sync, input msg, input inj_en, input inj_pos,
                    output busy, output valid, output codeword);
`else
    modport master (output sync, output msg,
                    input busy, input valid, input codeword);
    modport slave  (input sync, input msg,
                    output busy, output valid, output codeword);
`endif

endinterface

// File: rtl/crc16_lfsr.sv
// Registered bit-serial CRC-16 LFSR. The decoder's syndrome path reuses it,
// so it knows nothing about framing: load presets it, step shifts one data bit in.
module crc16_lfsr
    import crc16_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             step,
    input  logic             din,
    output logic [CRC_W-1:0] crc
);

    logic [CRC_W-1:0] crc_q;
    logic             fb;

    assign fb  = crc_q[CRC_W-1] ^ din;
    assign crc = crc_q;

    // Preset on load (takes priority), otherwise shift one message bit per step.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            crc_q <= CRC16_INIT;
        end else if (load) begin
            crc_q <= CRC16_INIT;
        end else if (step) begin
            crc_q <= {crc_q[CRC_W-2:0], 1'b0} ^ (fb ? CRC16_POLY : CRC_W'(0));
        end
    end

endmodule

// File: rtl/crc16_serial_encoder.sv
// Bit-serial CRC-16 encoder feeding the CRC-16 decoder. A 16-bit message is
// captured on sync, shifted MSB-first through the LFSR over 16 cycles, and
// presented as the systematic codeword {msg, crc} with a one-cycle valid.
// Optional feature macro: CRC16_ENC_ERRINJ_EN adds single-bit error injection
// (the CRC itself is always computed on clean data).
module crc16_serial_encoder
    import crc16_pkg::*;
(
    input  logic                   clk,
    input  logic                   reset,
    crc16_serial_encoder_if.slave  bus
);

    enc_state_t        state_q, state_d;
    logic [3:0]        cnt_q;
    logic [DATA_W-1:0] shreg_q;
    logic [DATA_W-1:0] msg_q;
    logic [CW_W-1:0]   codeword_q;
    logic              valid_q;
    logic [CRC_W-1:0]  lfsr_crc;

    logic              accept;
    logic              shifting;
    logic              finishing;

`ifdef CRC16_ENC_ERRINJ_EN
    logic              inj_en_q;
    logic [4:0]        inj_pos_q;
    logic [CW_W-1:0]   inj_mask;

    assign inj_mask = inj_en_q ? (CW_W'(1) << inj_pos_q) : '0;
`endif

    assign bus.busy     = (state_q != IDLE);
    assign bus.valid    = valid_q;
    assign bus.codeword = codeword_q;

    crc16_lfsr u_lfsr (
        .clk   (clk),
        .reset (reset),
        .load  (accept),
        .step  (shifting),
        .din   (shreg_q[DATA_W-1]),
        .crc   (lfsr_crc)
    );

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and per-state strobes; sync only matters when idle.
    always_comb begin
        state_d   = state_q;
        accept    = 1'b0;
        shifting  = 1'b0;
        finishing = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.sync) begin
                    accept  = 1'b1;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                shifting = 1'b1;
                if (cnt_q == 4'd15) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                finishing = 1'b1;
                state_d   = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Message capture, shift register, bit counter and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q      <= 4'd0;
            shreg_q    <= '0;
            msg_q      <= '0;
            codeword_q <= '0;
            valid_q    <= 1'b0;
        end else begin
            valid_q <= finishing;
            if (accept) begin
                cnt_q   <= 4'd0;
                shreg_q <= bus.msg;
                msg_q   <= bus.msg;
            end else if (shifting) begin
                cnt_q   <= cnt_q + 4'd1;
                shreg_q <= {shreg_q[DATA_W-2:0], 1'b0};
            end
            if (finishing) begin
`ifdef CRC16_ENC_ERRINJ_EN
                codeword_q <= {msg_q, lfsr_crc} ^ inj_mask;
`else
                codeword_q <= {msg_q, lfsr_crc};
`endif
            end
        end
    end

`ifdef CRC16_ENC_ERRINJ_EN
    // Injection controls travel with the message they were sampled alongside.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            inj_en_q  <= 1'b0;
            inj_pos_q <= 5'd0;
        end else if (accept) begin
            inj_en_q  <= bus.inj_en;
            inj_pos_q <= bus.inj_pos;
        end
    end
`endif

endmodule

// File: tb/tb_crc16_serial_encoder.sv
// Directed self-checking bench for crc16_serial_encoder with hand-computed
// CRC-16/0x8005 codewords. Build with CRC16_ENC_ERRINJ_EN to cover injection.
module tb_crc16_serial_encoder;

    logic clk;
    logic reset;
    int   errors;
    int   checks;

    crc16_serial_encoder_if bus ();

    crc16_serial_encoder dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // 100 MHz free-running clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Launch one encode and wait (bounded) for valid; reports latency in edges
    // after the accepting edge and how many sampled cycles busy was high.
    task automatic applyStimulus(input logic [15:0] m, output logic [31:0] cw,
                                 output int lat, output int busy_cnt);
        bus.msg  = m;
        bus.sync = 1'b1;
        @(posedge clk); #1;
        bus.sync = 1'b0;
        lat      = -1;
        busy_cnt = 0;
        for (int k = 1; k <= 40; k++) begin
            if (bus.busy) busy_cnt++;
            @(posedge clk); #1;
            if (bus.valid) begin
                lat = k;
                break;
            end
        end
        cw = bus.codeword;
    endtask

    task automatic test_reset();
        reset    = 1'b1;
        bus.sync = 1'b0;
        bus.msg  = 16'h0000;
`ifdef CRC16_ENC_ERRINJ_EN
        bus.inj_en  = 1'b0;
        bus.inj_pos = 5'd0;
`endif
        #20;
        checks++;
        if (bus.busy !== 1'b0) begin
            errors++; $display("[TB] FAIL reset_busy: got %b want 0", bus.busy);
        end
        checks++;
        if (bus.valid !== 1'b0) begin
            errors++; $display("[TB] FAIL reset_valid: got %b want 0", bus.valid);
        end
        checks++;
        if (bus.codeword !== 32'h0) begin
            errors++; $display("[TB] FAIL reset_codeword: got %h want 00000000", bus.codeword);
        end
        #10;
        reset = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_zero_msg();
        logic [31:0] cw;
        int lat, bc;
        applyStimulus(16'h0000, cw, lat, bc);
        checks++;
        if (lat !== 17) begin
            errors++; $display("[TB] FAIL zero_latency: got %0d want 17", lat);
        end
        checks++;
        if (cw !== 32'h00000000) begin
            errors++; $display("[TB] FAIL zero_codeword: got %h want 00000000", cw);
        end
        @(posedge clk); #1;
        checks++;
        if (bus.valid !== 1'b0) begin
            errors++; $display("[TB] FAIL valid_one_cycle: got %b want 0", bus.valid);
        end
    endtask

    task automatic test_single_bits();
        logic [31:0] cw;
        int lat, bc;
        applyStimulus(16'h0001, cw, lat, bc);
        checks++;
        if (cw !== 32'h00018005) begin
            errors++; $display("[TB] FAIL msg0001: got %h want 00018005", cw);
        end
        checks++;
        if (lat !== 17) begin
            errors++; $display("[TB] FAIL msg0001_latency: got %0d want 17", lat);
        end
        applyStimulus(16'h0002, cw, lat, bc);
        checks++;
        if (cw !== 32'h0002800F) begin
            errors++; $display("[TB] FAIL msg0002: got %h want 0002800f", cw);
        end
        checks++;
        if (lat !== 17) begin
            errors++; $display("[TB] FAIL msg0002_latency: got %0d want 17", lat);
        end
    endtask

    task automatic test_linearity();
        logic [31:0] cw;
        int lat, bc;
        applyStimulus(16'h0003, cw, lat, bc);
        checks++;
        if (cw !== 32'h0003000A) begin
            errors++; $display("[TB] FAIL msg0003: got %h want 0003000a", cw);
        end
        checks++;
        if (bc !== 17) begin
            errors++; $display("[TB] FAIL busy_cycles: got %0d want 17", bc);
        end
        checks++;
        if (bus.busy !== 1'b0) begin
            errors++; $display("[TB] FAIL busy_at_valid: got %b want 0", bus.busy);
        end
    endtask

    task automatic test_sync_while_busy();
        int lat;
        bus.msg  = 16'h0002;
        bus.sync = 1'b1;
        @(posedge clk); #1;
        bus.sync = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        bus.msg  = 16'hFFFF;
        bus.sync = 1'b1;
        @(posedge clk); #1;
        bus.sync = 1'b0;
        lat = -1;
        for (int k = 7; k <= 40; k++) begin
            @(posedge clk); #1;
            if (bus.valid) begin
                lat = k;
                break;
            end
        end
        checks++;
        if (lat !== 17) begin
            errors++; $display("[TB] FAIL busy_sync_latency: got %0d want 17", lat);
        end
        checks++;
        if (bus.codeword !== 32'h0002800F) begin
            errors++; $display("[TB] FAIL busy_sync_codeword: got %h want 0002800f", bus.codeword);
        end
        bus.msg = 16'h0000;
    endtask

    task automatic test_back_to_back();
        int lat1, lat2;
        logic [31:0] cw1;
        bus.msg  = 16'h0001;
        bus.sync = 1'b1;
        @(posedge clk); #1;
        bus.msg = 16'h0002;
        lat1 = -1;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk); #1;
            if (bus.valid) begin
                lat1 = k;
                break;
            end
        end
        cw1  = bus.codeword;
        lat2 = -1;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk); #1;
            if (bus.valid) begin
                lat2 = k;
                break;
            end
        end
        bus.sync = 1'b0;
        checks++;
        if (lat1 !== 17) begin
            errors++; $display("[TB] FAIL b2b_first_latency: got %0d want 17", lat1);
        end
        checks++;
        if (cw1 !== 32'h00018005) begin
            errors++; $display("[TB] FAIL b2b_first_codeword: got %h want 00018005", cw1);
        end
        checks++;
        if (lat2 !== 18) begin
            errors++; $display("[TB] FAIL b2b_period: got %0d want 18", lat2);
        end
        checks++;
        if (bus.codeword !== 32'h0002800F) begin
            errors++; $display("[TB] FAIL b2b_second_codeword: got %h want 0002800f", bus.codeword);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid_shift();
        int seen;
        logic [31:0] cw;
        int lat, bc;
        bus.msg  = 16'h0001;
        bus.sync = 1'b1;
        @(posedge clk); #1;
        bus.sync = 1'b0;
        repeat (8) @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if (bus.busy !== 1'b0) begin
            errors++; $display("[TB] FAIL midreset_busy: got %b want 0", bus.busy);
        end
        checks++;
        if (bus.codeword !== 32'h0) begin
            errors++; $display("[TB] FAIL midreset_codeword: got %h want 00000000", bus.codeword);
        end
        @(posedge clk); @(posedge clk); #3;
        reset = 1'b0;
        seen = 0;
        for (int k = 0; k < 25; k++) begin
            @(posedge clk); #1;
            if (bus.valid) seen++;
        end
        checks++;
        if (seen !== 0) begin
            errors++; $display("[TB] FAIL midreset_no_valid: got %0d pulses want 0", seen);
        end
        applyStimulus(16'h0002, cw, lat, bc);
        checks++;
        if (cw !== 32'h0002800F) begin
            errors++; $display("[TB] FAIL post_reset_codeword: got %h want 0002800f", cw);
        end
    endtask

`ifdef CRC16_ENC_ERRINJ_EN
    task automatic test_errinj();
        logic [31:0] cw;
        int lat, bc;
        bus.inj_en  = 1'b1;
        bus.inj_pos = 5'd0;
        applyStimulus(16'h0001, cw, lat, bc);
        checks++;
        if (cw !== 32'h00018004) begin
            errors++; $display("[TB] FAIL errinj_bit0: got %h want 00018004", cw);
        end
        bus.inj_pos = 5'd31;
        applyStimulus(16'h0001, cw, lat, bc);
        checks++;
        if (cw !== 32'h80018005) begin
            errors++; $display("[TB] FAIL errinj_bit31: got %h want 80018005", cw);
        end
        bus.inj_en = 1'b0;
        applyStimulus(16'h0001, cw, lat, bc);
        checks++;
        if (cw !== 32'h00018005) begin
            errors++; $display("[TB] FAIL errinj_off: got %h want 00018005", cw);
        end
    endtask
`endif

    // Scenario sequence and summary.
    initial begin
        errors = 0;
        checks = 0;
        test_reset();
        test_zero_msg();
        test_single_bits();
        test_linearity();
        test_sync_while_busy();
        test_back_to_back();
        test_reset_mid_shift();
`ifdef CRC16_ENC_ERRINJ_EN
        test_errinj();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
